// File: rtl/hum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hum_pkg
// Description : Shared types and constants for the humidity controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hum_pkg;

    localparam int HUM_W         = 8;
    localparam int TIMEOUT_STEPS = 64;
    localparam int HUM_RST_VAL   = 50;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RAISE = 2'd2,
        ST_LOWER = 2'd3
    } hum_state_e;

endpackage
`default_nettype wire

// File: rtl/hum_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : hum_step_timer
// Description : Down-counting step period timer with reload; tick on zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hum_step_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    import hum_pkg::*;

    logic [DIV_W-1:0] r_cnt;

    // Counter rests at zero whenever the controller is not correcting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= div;
        end else if (run) begin
            r_cnt <= (r_cnt == '0) ? div : (r_cnt - DIV_W'(1));
        end else begin
            r_cnt <= '0;
        end
    end

    assign tick = run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/hum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hum_ctrl
// Description : Hysteretic humidity controller issuing paced inc/dec steps
//               with a sticky correction-timeout alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module hum_ctrl #(
    parameter int HUM_W         = hum_pkg::HUM_W,
    parameter int TIMEOUT_STEPS = hum_pkg::TIMEOUT_STEPS
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             ctrl_en,
    input  logic [HUM_W-1:0] hum_setpoint,
    input  logic [3:0]       hum_band,
    input  logic [7:0]       step_div,
    input  logic [HUM_W-1:0] real_time_hum,
    output logic             hum_inc_en,
    output logic             hum_dec_en,
    output logic [1:0]       hum_state,
    output logic             hum_alarm
);
    import hum_pkg::*;

    localparam int               c_TMO_W   = $clog2(TIMEOUT_STEPS + 1);
    localparam logic [HUM_W-1:0] c_HUM_MAX = '1;

    hum_state_e         r_state;
    hum_state_e         w_state_nxt;
    logic               r_inc;
    logic               r_dec;
    logic               r_alarm;
    logic [c_TMO_W-1:0] r_tmo;

    logic [HUM_W:0]     w_lo_raw;
    logic [HUM_W:0]     w_hi_raw;
    logic [HUM_W-1:0]   w_lo_th;
    logic [HUM_W-1:0]   w_hi_th;
    logic               w_in_corr;
    logic               w_nxt_corr;
    logic               w_load;
    logic               w_tick;
    logic               w_tmo_hit;
    logic               w_inc_nxt;
    logic               w_dec_nxt;

    // Thresholds are formed one bit wider so under/overflow can be saturated.
    assign w_lo_raw = {1'b0, hum_setpoint} - (HUM_W+1)'(hum_band);
    assign w_hi_raw = {1'b0, hum_setpoint} + (HUM_W+1)'(hum_band);
    assign w_lo_th  = w_lo_raw[HUM_W] ? '0        : w_lo_raw[HUM_W-1:0];
    assign w_hi_th  = w_hi_raw[HUM_W] ? c_HUM_MAX : w_hi_raw[HUM_W-1:0];

    assign w_in_corr  = (r_state == ST_RAISE) || (r_state == ST_LOWER);
    assign w_nxt_corr = (w_state_nxt == ST_RAISE) || (w_state_nxt == ST_LOWER);
    assign w_load     = w_nxt_corr && !w_in_corr;
    assign w_tmo_hit  = (r_tmo == c_TMO_W'(TIMEOUT_STEPS));

    hum_step_timer #(
        .DIV_W (8)
    ) u_step_timer (
        .clk  (pclk),
        .rst  (preset),
        .run  (w_in_corr),
        .load (w_load),
        .div  (step_div),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_inc_nxt   = 1'b0;
        w_dec_nxt   = 1'b0;
        if (!ctrl_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_HOLD;
                ST_HOLD: begin
                    if (!r_alarm) begin
                        if (real_time_hum < w_lo_th) begin
                            w_state_nxt = ST_RAISE;
                        end else if (real_time_hum > w_hi_th) begin
                            w_state_nxt = ST_LOWER;
                        end
                    end
                end
                ST_RAISE: begin
                    if (w_tmo_hit || (real_time_hum >= hum_setpoint)) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_LOWER: begin
                    if (w_tmo_hit || (real_time_hum <= hum_setpoint)) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        // A step is only issued when the correction continues past this edge.
        w_inc_nxt = w_tick && (r_state == ST_RAISE) && (w_state_nxt == ST_RAISE)
                    && (real_time_hum != c_HUM_MAX);
        w_dec_nxt = w_tick && (r_state == ST_LOWER) && (w_state_nxt == ST_LOWER)
                    && (real_time_hum != '0);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_alarm <= 1'b0;
            r_tmo   <= '0;
        end else begin
            r_inc <= w_inc_nxt;
            r_dec <= w_dec_nxt;
            if (!w_nxt_corr) begin
                r_tmo <= '0;
            end else if (w_inc_nxt || w_dec_nxt) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end
            if (!ctrl_en) begin
                r_alarm <= 1'b0;
            end else if (w_in_corr && w_tmo_hit) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign hum_state  = r_state;
    assign hum_inc_en = r_inc;
    assign hum_dec_en = r_dec;
    assign hum_alarm  = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_hum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hum_ctrl
// Description : Self-checking bench for hum_ctrl with a closed-loop sensor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hum_ctrl;

    localparam int c_TMO = 64;

    logic       pclk          = 1'b0;
    logic       preset        = 1'b1;
    logic       ctrl_en       = 1'b0;
    logic [7:0] hum_setpoint  = '0;
    logic [3:0] hum_band      = '0;
    logic [7:0] step_div      = '0;
    logic [7:0] real_time_hum = '0;
    logic       hum_inc_en;
    logic       hum_dec_en;
    logic [1:0] hum_state;
    logic       hum_alarm;

    bit sensor_on = 1'b1;
    int n_chk     = 0;
    int n_pass    = 0;
    int n_inc     = 0;
    int n_dec     = 0;

    // Reference model: values expected to be visible after the latest edge.
    int m_state;
    bit m_inc;
    bit m_dec;
    bit m_alarm;
    int m_k;
    int m_np;

    hum_ctrl #(
        .HUM_W         (8),
        .TIMEOUT_STEPS (c_TMO)
    ) dut (
        .pclk          (pclk),
        .preset        (preset),
        .ctrl_en       (ctrl_en),
        .hum_setpoint  (hum_setpoint),
        .hum_band      (hum_band),
        .step_div      (step_div),
        .real_time_hum (real_time_hum),
        .hum_inc_en    (hum_inc_en),
        .hum_dec_en    (hum_dec_en),
        .hum_state     (hum_state),
        .hum_alarm     (hum_alarm)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_inc = 0; m_dec = 0; m_alarm = 0; m_k = 0; m_np = 0;
    endtask

    // State mapping: 0 idle, 1 hold, 2 raise, 3 lower. A correction ticks on
    // every cycle whose index since entry is div modulo (div+1).
    task automatic model_adv(input bit en, input int sp, input int band,
                             input int div, input int hum);
        int lo, hi, ns;
        bit na, tick, ni, nd, cur_c, nxt_c;
        lo = sp - band; if (lo < 0)   lo = 0;
        hi = sp + band; if (hi > 255) hi = 255;
        ns = m_state;
        na = m_alarm;
        if (!en) begin
            ns = 0; na = 0;
        end else begin
            case (m_state)
                0: ns = 1;
                1: if (!m_alarm) begin
                       if (hum < lo) ns = 2;
                       else if (hum > hi) ns = 3;
                   end
                2: if (m_np >= c_TMO) begin ns = 1; na = 1; end
                   else if (hum >= sp) ns = 1;
                3: if (m_np >= c_TMO) begin ns = 1; na = 1; end
                   else if (hum <= sp) ns = 1;
                default: ns = 0;
            endcase
        end
        cur_c = (m_state >= 2);
        nxt_c = (ns >= 2);
        tick  = cur_c && ((m_k % (div + 1)) == div);
        ni    = tick && (m_state == 2) && (ns == 2) && (hum != 255);
        nd    = tick && (m_state == 3) && (ns == 3) && (hum != 0);
        if (cur_c && nxt_c) begin
            m_k++;
            if (ni || nd) m_np++;
        end else begin
            m_k = 0; m_np = 0;
        end
        m_state = ns; m_alarm = na; m_inc = ni; m_dec = nd;
    endtask

    // Called at a falling edge: predict, clock, compare, then move the sensor.
    task automatic step();
        model_adv(ctrl_en, int'(hum_setpoint), int'(hum_band), int'(step_div),
                  int'(real_time_hum));
        @(posedge pclk);
        @(negedge pclk);
        chk("state", int'(hum_state), m_state);
        chk("inc",   int'(hum_inc_en), int'(m_inc));
        chk("dec",   int'(hum_dec_en), int'(m_dec));
        chk("alarm", int'(hum_alarm), int'(m_alarm));
        if (hum_inc_en) n_inc++;
        if (hum_dec_en) n_dec++;
        if (sensor_on) begin
            if (hum_inc_en && real_time_hum != 8'hFF) real_time_hum = real_time_hum + 8'd1;
            if (hum_dec_en && real_time_hum != 8'h00) real_time_hum = real_time_hum - 8'd1;
        end
    endtask

    task automatic do_reset();
        #2 preset = 1'b1;
        #1;
        chk("rst_state", int'(hum_state), 0);
        chk("rst_inc",   int'(hum_inc_en), 0);
        chk("rst_dec",   int'(hum_dec_en), 0);
        chk("rst_alarm", int'(hum_alarm), 0);
        model_reset();
        @(negedge pclk);
        preset = 1'b0;
    endtask

    task automatic go_idle();
        ctrl_en = 1'b0;
        step();
        n_inc = 0;
        n_dec = 0;
    endtask

    initial begin
        model_reset();
        @(negedge pclk);
        @(negedge pclk);
        chk("por_state", int'(hum_state), 0);
        chk("por_inc",   int'(hum_inc_en), 0);
        chk("por_dec",   int'(hum_dec_en), 0);
        chk("por_alarm", int'(hum_alarm), 0);
        preset = 1'b0;

        // In-band: no activity.
        hum_setpoint = 8'd50; hum_band = 4'd2; step_div = 8'd3;
        real_time_hum = 8'd50; sensor_on = 1'b1; ctrl_en = 1'b1;
        n_inc = 0; n_dec = 0;
        repeat (100) step();
        chk("inband_pulses", n_inc + n_dec, 0);
        chk("inband_state", int'(hum_state), 1);

        // Closed-loop raise, one step every four cycles.
        go_idle();
        real_time_hum = 8'd40; ctrl_en = 1'b1;
        repeat (80) step();
        chk("raise_inc", n_inc, 10);
        chk("raise_dec", n_dec, 0);
        chk("raise_hum", int'(real_time_hum), 50);
        chk("raise_end", int'(hum_state), 1);

        // Closed-loop lower, one step every cycle.
        go_idle();
        real_time_hum = 8'd60; step_div = 8'd0; ctrl_en = 1'b1;
        repeat (40) step();
        chk("lower_dec", n_dec, 10);
        chk("lower_inc", n_inc, 0);
        chk("lower_hum", int'(real_time_hum), 50);
        chk("lower_end", int'(hum_state), 1);

        // Frozen sensor: timeout alarm.
        go_idle();
        sensor_on = 1'b0; real_time_hum = 8'd10; ctrl_en = 1'b1;
        for (int i = 0; i < 400 && !hum_alarm; i++) step();
        chk("tmo_alarm", int'(hum_alarm), 1);
        chk("tmo_pulses", n_inc, c_TMO);
        chk("tmo_state", int'(hum_state), 1);
        n_inc = 0;
        repeat (30) step();
        chk("tmo_quiet", n_inc + n_dec, 0);
        chk("tmo_sticky", int'(hum_alarm), 1);
        ctrl_en = 1'b0;
        step();
        chk("tmo_clear", int'(hum_alarm), 0);
        chk("tmo_idle", int'(hum_state), 0);

        // Sensor range limits.
        sensor_on = 1'b1;
        go_idle();
        hum_setpoint = 8'd255; hum_band = 4'd15; real_time_hum = 8'd255; ctrl_en = 1'b1;
        repeat (20) step();
        chk("top_no_inc", n_inc, 0);
        go_idle();
        hum_setpoint = 8'd0; real_time_hum = 8'd0; ctrl_en = 1'b1;
        repeat (20) step();
        chk("bot_no_dec", n_dec, 0);

        // Reset in the middle of a raise.
        go_idle();
        hum_setpoint = 8'd50; hum_band = 4'd2; step_div = 8'd3;
        real_time_hum = 8'd40; ctrl_en = 1'b1;
        for (int i = 0; i < 20 && hum_state != 2'd2; i++) step();
        chk("mid_raise", int'(hum_state), 2);
        repeat (5) step();
        do_reset();
        repeat (3) step();

        // Randomized phases with setpoint wander, enable drops and resets.
        for (int p = 0; p < 30; p++) begin
            ctrl_en = 1'b0;
            step();
            hum_setpoint  = 8'($urandom_range(0, 255));
            hum_band      = 4'($urandom_range(0, 15));
            step_div      = 8'($urandom_range(0, 4));
            real_time_hum = 8'($urandom_range(0, 255));
            sensor_on     = ($urandom_range(0, 3) != 0);
            ctrl_en       = 1'b1;
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 39) == 0) hum_setpoint = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 299) == 0) do_reset();
                ctrl_en = ($urandom_range(0, 249) != 0);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hum_ctrl.md
HUM_CTRL -- requirements
Module: hum_ctrl

Interface
REQ-001 Parameter HUM_W, default 8, humidity data width.
REQ-002 Parameter TIMEOUT_STEPS, default 64, maximum step pulses per correction before alarm.
REQ-003 pclk  input  1  sole clock; all logic on its rising edge.
REQ-004 preset  input  1  asynchronous, active-high reset.
REQ-005 ctrl_en  input  1  controller enable; low forces IDLE.
REQ-006 hum_setpoint  input  HUM_W  target humidity.
REQ-007 hum_band  input  4  hysteresis half-width around setpoint.
REQ-008 step_div  input  8  step period minus one, in pclk cycles.
REQ-009 real_time_hum  input  HUM_W  current humidity from the sensor model.
REQ-010 hum_inc_en  output  1  one-cycle request to increment humidity.
REQ-011 hum_dec_en  output  1  one-cycle request to decrement humidity.
REQ-012 hum_state  output  2  current FSM state encoding.
REQ-013 hum_alarm  output  1  sticky correction-timeout flag.

Function
REQ-014 The FSM SHALL have states IDLE=0, HOLD=1, RAISE=2, LOWER=3.
REQ-015 The FSM SHALL enter IDLE from any state whenever ctrl_en=0, clearing hum_alarm, the step counter and the timeout counter.
REQ-016 IDLE -> HOLD SHALL occur on the first cycle with ctrl_en=1.
REQ-017 The low threshold SHALL be max(hum_setpoint - hum_band, 0) and the high threshold min(hum_setpoint + hum_band, 2^HUM_W - 1), both computed HUM_W+1 bits wide and saturated.
REQ-018 HOLD -> RAISE SHALL occur when real_time_hum < low threshold.
REQ-019 HOLD -> LOWER SHALL occur when real_time_hum > high threshold.
REQ-020 Otherwise the FSM SHALL stay in HOLD.
REQ-021 RAISE -> HOLD SHALL occur when real_time_hum >= hum_setpoint.
REQ-022 LOWER -> HOLD SHALL occur when real_time_hum <= hum_setpoint.
REQ-023 Thresholds and setpoint SHALL be sampled combinationally every cycle, so mid-correction setpoint changes take effect on the next cycle.
REQ-024 On entry to RAISE or LOWER, the step counter SHALL load step_div.
REQ-025 In RAISE or LOWER the step counter SHALL decrement each cycle.
REQ-026 When the step counter is 0 in RAISE or LOWER, the block SHALL register a one-cycle step pulse and reload step_div.
REQ-027 With step_div=0, a pulse SHALL occur every cycle from the cycle after entry; overshoot of one LSB SHALL be accepted in that case.
REQ-028 hum_inc_en SHALL pulse only in RAISE, and hum_dec_en only in LOWER.
REQ-029 hum_inc_en and hum_dec_en SHALL never be high in the same cycle.
REQ-030 hum_inc_en SHALL be suppressed when real_time_hum = 2^HUM_W-1, and hum_dec_en when real_time_hum = 0 (no sensor wrap).
REQ-031 The timeout counter SHALL count step pulses per correction and clear on every return to HOLD.
REQ-032 When the timeout counter reaches TIMEOUT_STEPS, hum_alarm SHALL set and stay set until ctrl_en=0 or reset.
REQ-033 After an alarm, the FSM SHALL go to HOLD and pulsing SHALL stop.
REQ-034 While hum_alarm=1 the FSM SHALL remain in HOLD.
REQ-035 hum_state, hum_inc_en, hum_dec_en and hum_alarm SHALL all be registered outputs.

Reset
REQ-036 When preset=1, asynchronously: state=IDLE, hum_inc_en=0, hum_dec_en=0, hum_alarm=0, step counter=0, timeout counter=0.
REQ-037 Reset asserted mid-correction SHALL abort the correction with no further pulse.
REQ-038 The first post-reset transition SHALL follow REQ-016.

Structure
REQ-039 Package hum_pkg SHALL hold the state enum hum_state_e, HUM_W, the default TIMEOUT_STEPS and the reset humidity constant 50.
REQ-040 The step counter and reload logic SHALL be a sub-module hum_step_timer with inputs run, load and div, and output tick.

Verification
REQ-041 Reset, ctrl_en=1, setpoint=50, band=2, hum=50 -> HOLD, no pulses for 100 cycles.
REQ-042 hum=40, setpoint=50, band=2, step_div=3, sensor model connected -> RAISE; inc pulse every 4 cycles; HOLD when hum=50; 10 pulses total.
REQ-043 hum=60, setpoint=50, band=2, step_div=0 -> LOWER; dec pulse every cycle; HOLD at hum<=50; never inc.
REQ-044 Sensor frozen at 10, setpoint=50, TIMEOUT_STEPS=64 -> alarm after 64th pulse; HOLD; alarm cleared by ctrl_en=0.
REQ-045 setpoint=255, band=15, hum=255 -> no inc pulse; setpoint=0, hum=0 -> no dec pulse.
REQ-046 preset asserted mid-RAISE -> outputs 0 immediately, state IDLE.
